seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 180 ++++++++++++++++++
 tb/tb_seq_alu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/logic/SLT/LSL and an iterative shift-add
// multiplier, with valid/ready handshakes on both the request and result sides.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  // state | meaning
  // IDLE  | no result held, ready for a request
  // MUL   | shift-add multiply in progress, one multiplier bit per cycle
  // OUT   | result and flags presented, waiting for out_ready

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_LSL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [SW:0]      cnt;
  logic [SW-1:0]    bit_idx;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  logic             accept;
  logic             mul_done;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_flags;

  assign accept   = in_valid && in_ready;
  assign mul_done = (state == S_MUL) && (cnt == (SW+1)'(1));
  assign sh       = b[SW-1:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = (op == OP_MUL) ? S_MUL : S_OUT;
      end
      S_MUL: begin
        if (mul_done) state_nxt = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (accept) state_nxt = (op == OP_MUL) ? S_MUL : S_OUT;
          else        state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE:  in_ready = rst_n;
      S_OUT: begin
        in_ready  = rst_n && out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------- single-cycle ALU
  always_comb begin
    sum     = '0;
    shl     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SLT: alu_res = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      OP_LSL: begin
        // Bit WIDTH of the widened shift is a[WIDTH-sh], the last bit shifted out.
        shl     = {1'b0, a} << sh;
        alu_res = shl[WIDTH-1:0];
        alu_c   = shl[WIDTH];
      end
      default: alu_res = '0;
    endcase
    alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
  end

  // ------------------------------------------------------- shift-add multiply
  // cnt counts down from WIDTH; the bit under test rises from 0 as it falls,
  // so the operand registers never need to shift.
  assign bit_idx = SW'((SW+1)'(WIDTH) - cnt);
  assign acc_nxt = acc + (b_q[bit_idx] ? (a_q << bit_idx) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      if (op == OP_MUL) begin
        acc <= '0;
        cnt <= (SW+1)'(WIDTH);
      end else begin
        result_q <= alu_res;
        flags_q  <= alu_flags;
      end
    end else if (state == S_MUL) begin
      acc <= acc_nxt;
      cnt <= cnt - (SW+1)'(1);
      if (mul_done) begin
        result_q <= acc_nxt;
        flags_q  <= {acc_nxt[WIDTH-1], (acc_nxt == '0), 2'b00};
      end
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): vector table for every op plus
// hand-written hold/back-to-back and reset-during-multiply sequences.
module tb_seq_alu;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [3:0]    flags;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency from the accept edge, check and consume.
  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int lat;
    logic busy_seen;
    busy_seen = 1'b0;
    in_valid  = 1'b1;
    a         = v.a;
    b         = v.b;
    op        = v.op;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("vec%0d ready_before_accept", idx), {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0; b = '0; op = 3'b000;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("vec%0d latency", idx), 64'(lat), (v.op == 3'b111) ? 64'd33 : 64'd1);
    check($sformatf("vec%0d in_ready_low_while_busy", idx), {63'd0, busy_seen}, 64'd0);
    check($sformatf("vec%0d result", idx), 64'(result), 64'(v.res));
    check($sformatf("vec%0d flags", idx), 64'(flags), 64'(v.flg));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("vec%0d consumed", idx), {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int lat;
    int stale;
    logic busy_seen;

    //            op      a             b             result        NZCV
    vecs[0]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
    vecs[1]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
    vecs[2]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
    vecs[3]  = '{3'b001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000};
    vecs[4]  = '{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
    vecs[5]  = '{3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000};
    vecs[6]  = '{3'b011, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0100};
    vecs[7]  = '{3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 4'b1000};
    vecs[8]  = '{3'b101, 32'hFFFFFFFB, 32'h00000003, 32'h00000001, 4'b0000};
    vecs[9]  = '{3'b101, 32'h00000003, 32'hFFFFFFFB, 32'h00000000, 4'b0100};
    vecs[10] = '{3'b110, 32'h80000001, 32'h00000001, 32'h00000002, 4'b0010};
    vecs[11] = '{3'b110, 32'h80000001, 32'h00000000, 32'h80000001, 4'b1000};
    vecs[12] = '{3'b110, 32'h00000001, 32'h0000003F, 32'h80000000, 4'b1000};
    vecs[13] = '{3'b110, 32'h00000003, 32'h0000001F, 32'h80000000, 4'b1010};
    vecs[14] = '{3'b111, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 4'b1000};
    vecs[15] = '{3'b111, 32'h00000007, 32'h00000006, 32'h0000002A, 4'b0000};
    vecs[16] = '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset flags", 64'(flags), 64'd0);
    check("reset in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Hold result with out_ready low, then consume and accept on the same edge.
    in_valid = 1'b1; op = 3'b000; a = 32'h7FFFFFFF; b = 32'h00000001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d out_valid", k), {63'd0, out_valid}, 64'd1);
      check($sformatf("hold%0d result", k), 64'(result), 64'h80000000);
      check($sformatf("hold%0d flags", k), 64'(flags), 64'b1001);
    end
    out_ready = 1'b1; in_valid = 1'b1; op = 3'b000; a = 32'd1; b = 32'd1;
    #1;
    check("b2b in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b out_valid", {63'd0, out_valid}, 64'd1);
    check("b2b result", 64'(result), 64'd2);
    check("b2b flags", 64'(flags), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b consumed", {63'd0, out_valid}, 64'd0);

    // Reset asynchronously during cycle 10 of a multiply.
    in_valid = 1'b1; op = 3'b111; a = 32'h0000FFFF; b = 32'h00010001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy_seen = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (in_ready || out_valid) busy_seen = 1'b1;
      @(posedge clk); #1;
    end
    check("mulrst busy before reset", {63'd0, busy_seen}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mulrst out_valid", {63'd0, out_valid}, 64'd0);
    check("mulrst result", 64'(result), 64'd0);
    check("mulrst flags", 64'(flags), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("mulrst in_ready after release", {63'd0, in_ready}, 64'd1);
    stale = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("mulrst stale output cycles", 64'(stale), 64'd0);

    lat = 0;
    in_valid = 1'b1; op = 3'b100; a = 32'h0000000F; b = 32'h000000F0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("post-abort xor result", 64'(result), 64'h000000FF);
    check("post-abort out_valid", {63'd0, out_valid}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
